// File: rtl/tt_pkg.sv
// Shared types and sizing constants for the 7-input truth-table sweep block.
package tt_pkg;
  localparam int NVARS   = 7;
  localparam int TT_BITS = 1 << NVARS;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, SWEEP, CHECK, DONE} state_t;
  typedef logic [TT_BITS-1:0] tt_t;
endpackage

// File: rtl/tt_dual_checker.sv
// Walks j = 0..63 over a held truth table, clearing self_dual whenever
// f(j) equals f(127-j); fin marks the final comparison cycle.
module tt_dual_checker
  import tt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic go,
  input  tt_t  tt,
  output logic self_dual,
  output logic fin
);

  logic [NVARS-2:0] j;
  logic             run;
  logic [NVARS-1:0] lo;
  logic [NVARS-1:0] hi;

  // 127-j is the bitwise complement of j in 7 bits
  assign lo  = {1'b0, j};
  assign hi  = ~lo;
  assign fin = run && (&j);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j         <= '0;
      run       <= 1'b0;
      self_dual <= 1'b0;
    end else if (clr) begin
      j         <= '0;
      run       <= 1'b0;
      self_dual <= 1'b0;
    end else if (go) begin
      j         <= '0;
      run       <= 1'b1;
      self_dual <= 1'b1;
    end else if (run) begin
      if (tt[lo] == tt[hi]) self_dual <= 1'b0;
      j <= j + 1'b1;
      if (&j) run <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 128 input vectors into the function under test, captures its
// output into a truth table and derives ones count and self-duality.
module tt_sweep_capture #(
  parameter int NVARS = 7,
  parameter int LAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [NVARS-1:0]        x_out,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [(1<<NVARS)-1:0]   truth_table,
  output logic [7:0]              ones_count,
  output logic                    self_dual
);
  import tt_pkg::*;

  localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TT_BITS - 1 + LAT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   slot;
  logic             cap_en;
  logic             accept;
  logic             chk_go;
  logic             chk_clr;
  logic             chk_fin;

  // slot = cnt - LAT; the borrow bit says the FUT output is not yet meaningful
  assign slot    = {1'b0, cnt} - {1'b0, LAT_C};
  assign cap_en  = !slot[CNT_W] && !slot[CNT_W-1];
  assign accept  = (state == IDLE) && start && !abort;
  assign chk_go  = (state == SWEEP) && (cnt == LAST_C) && !abort;
  assign chk_clr = abort || accept;
  assign x_out   = ((state == SWEEP) && !cnt[CNT_W-1]) ? cnt[NVARS-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      truth_table <= '0;
      ones_count  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
        valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state       <= SWEEP;
            cnt         <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            valid       <= 1'b0;
            busy        <= 1'b1;
          end
          SWEEP: begin
            if (cap_en) begin
              truth_table[slot[NVARS-1:0]] <= f_in;
              ones_count <= ones_count + {{(CNT_W-1){1'b0}}, f_in};
            end
            if (cnt == LAST_C) state <= CHECK;
            else               cnt   <= cnt + 1'b1;
          end
          CHECK: if (chk_fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  tt_dual_checker u_dual (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (chk_clr),
    .go        (chk_go),
    .tt        (truth_table),
    .self_dual (self_dual),
    .fin       (chk_fin)
  );

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: table of FUT functions on a LAT=0 instance, a pipelined
// majority on a LAT=2 instance, plus start/abort/reset corner sequences.
module tb_tt_sweep_capture;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic [6:0]   x0, x2;
  logic         f0, f2;
  logic         busy0, done0, valid0, sd0, busy2, done2, valid2, sd2;
  logic [127:0] tt0, tt2;
  logic [7:0]   ones0, ones2;

  int sel = 0;
  int checks = 0;
  int passes = 0;
  logic [6:0] x_at10;
  logic [127:0] golden = 128'hfee8eae8ece8e888eee8e8c8e8a8e880;
  logic p1 = 1'b0, p2 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    f0 = 1'b0;
    case (sel)
      0: f0 = x0[0];
      1: f0 = 1'b0;
      2: f0 = golden[x0];
      3: f0 = x0[0] & x0[1];
      default: f0 = 1'b0;
    endcase
  end

  // two-stage pipelined FUT for the LAT=2 instance
  always @(posedge clk) begin
    p1 <= maj3(x2[0], x2[1], x2[2]);
    p2 <= p1;
  end
  assign f2 = p2;

  tt_sweep_capture #(.NVARS(7), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .x_out(x0),
    .f_in(f0), .busy(busy0), .done(done0), .valid(valid0),
    .truth_table(tt0), .ones_count(ones0), .self_dual(sd0));

  tt_sweep_capture #(.NVARS(7), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .x_out(x2),
    .f_in(f2), .busy(busy2), .done(done2), .valid(valid2),
    .truth_table(tt2), .ones_count(ones2), .self_dual(sd2));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done0 && sd0) check("sd_implies_64_lat0", ones0, 64);
    if (done2 && sd2) check("sd_implies_64_lat2", ones2, 64);
  end

  // Starts a sweep on one instance; optional stray start pulse at pulse_at.
  task automatic run(input int which, input int pulse_at, output int dcyc);
    int cyc;
    bit seen;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    cyc = 0; seen = 0; dcyc = -1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start0 = (which == 0) && (cyc == pulse_at);
      start2 = 1'b0;
      if (cyc == 10) x_at10 = (which == 0) ? x0 : x2;
      if ((which == 0) ? done0 : done2) begin
        seen = 1;
        dcyc = cyc;
      end
    end
  endtask

  typedef struct {
    int           fsel;
    logic [127:0] tt;
    int           ones;
    bit           sd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dc;
    int cyc;
    bit seen;

    vecs[0] = '{0, {32{4'hA}}, 64, 1'b1};
    vecs[1] = '{1, 128'h0, 0, 1'b0};
    vecs[2] = '{2, 128'hfee8eae8ece8e888eee8e8c8e8a8e880, 64, 1'b1};
    vecs[3] = '{3, {32{4'h8}}, 32, 1'b0};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", valid0, 0);
    check("rst_x", x0, 0);
    check("rst_tt", tt0, 0);
    check("rst_ones_sd", {ones0, sd0}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      sel = vecs[i].fsel;
      run(0, 0, dc);
      check($sformatf("v%0d_done_cycle", i), dc, 193);
      check($sformatf("v%0d_x_at10", i), x_at10, 9);
      check($sformatf("v%0d_tt", i), tt0, vecs[i].tt);
      check($sformatf("v%0d_ones", i), ones0, vecs[i].ones);
      check($sformatf("v%0d_sd", i), sd0, vecs[i].sd);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done0, 0);
      check($sformatf("v%0d_valid_held", i), valid0, 1);
      check($sformatf("v%0d_busy_idle", i), busy0, 0);
    end

    // pipelined majority, LAT = 2
    run(2, 0, dc);
    check("lat2_done_cycle", dc, 195);
    check("lat2_tt", tt2, {16{8'hE8}});
    check("lat2_ones", ones2, 64);
    check("lat2_sd", sd2, 1);

    // stray start at cycle 50 must not disturb the sweep
    sel = 0;
    run(0, 50, dc);
    check("pulse50_done_cycle", dc, 193);
    check("pulse50_tt", tt0, {32{4'hA}});
    check("pulse50_ones_sd", {ones0, sd0}, {8'd64, 1'b1});

    // abort beats start in IDLE and drops a held valid
    @(negedge clk);
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    check("idle_abort_valid", valid0, 0);
    check("idle_abort_busy", busy0, 0);
    repeat (3) @(negedge clk);
    check("idle_abort_stays_idle", busy0, 0);

    // abort at cycle 70 of a sweep
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 70) begin
      @(negedge clk);
      cyc++;
      start0 = 1'b0;
      abort0 = (cyc == 70);
    end
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_valid", valid0, 0);
    check("abort_x", x0, 0);
    seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    check("abort_no_done", seen, 0);

    sel = 3;
    run(0, 0, dc);
    check("after_abort_done_cycle", dc, 193);
    check("after_abort_tt", tt0, {32{4'h8}});
    check("after_abort_ones", ones0, 32);

    // reset in the middle of CHECK
    sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 150) begin
      @(negedge clk);
      cyc++;
      start0 = 1'b0;
    end
    check("pre_reset_busy", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy0, 0);
    check("midrst_valid_done", {valid0, done0}, 0);
    check("midrst_tt", tt0, 0);
    check("midrst_ones_sd", {ones0, sd0}, 0);
    check("midrst_x", x0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy0 || done0 || valid0 || (x0 != 0)) seen = 1;
    end
    check("post_reset_idle", seen, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
